// File: rtl/turf_link_pkg.sv
// Shared types and constants for the TURF link receive path.
package turf_link_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LOCKING,
    LOCKED
  } deframe_state_t;

  localparam logic [31:0] TURF_TRAIN_PATTERN = 32'hA55A6996;
  localparam int          NIBBLES_PER_WORD   = 8;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter; a coincident increment and clear restarts the count at 1.
module sat_event_counter #(
  parameter int WIDTH = 16
) (
  input  logic             sysclk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: flops use non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (inc && clr) begin
      count <= WIDTH'(1);
    end else if (inc) begin
      if (count != '1) count <= count + 1'b1;
    end else if (clr) begin
      count <= '0;
    end
  end

endmodule

// File: rtl/turf_nibble_deframer.sv
// Aligns the 4-bit sysclk nibble stream to 32-bit words using a repeating training word
// and emits the non-training words; capture errors are counted and force a re-hunt.
module turf_nibble_deframer
  import turf_link_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = TURF_TRAIN_PATTERN,
  parameter int          LOCK_COUNT    = 16,
  parameter int          ERR_CNT_W     = 16
) (
  input  logic                 sysclk_i,
  input  logic                 rst_i,
  input  logic [3:0]           data_i,
  input  logic                 capture_err_i,
  input  logic                 relock_i,
  input  logic                 err_clr_i,
  output logic [31:0]          word_o,
  output logic                 word_valid_o,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int                  PHASE_W     = $clog2(NIBBLES_PER_WORD);
  localparam logic [PHASE_W-1:0]  LAST_PHASE  = PHASE_W'(NIBBLES_PER_WORD - 1);
  localparam logic [7:0]          LOCK_TARGET = 8'(LOCK_COUNT);

  deframe_state_t     state, state_next;
  logic [31:0]        sr;
  logic [PHASE_W-1:0] phase;
  logic [7:0]         match_cnt, match_cnt_next;
  logic               match, boundary, force_hunt, realign, emit;

  assign match      = (sr == TRAIN_PATTERN);
  assign boundary   = (phase == LAST_PHASE);
  assign force_hunt = capture_err_i | relock_i;

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) state <= HUNT;
    else       state <= state_next;
  end

  // NOTE: defaults first so every path assigns every output (no inferred latches).
  always_comb begin
    state_next     = state;
    match_cnt_next = match_cnt;
    realign        = 1'b0;
    if (force_hunt) begin
      state_next     = HUNT;
      match_cnt_next = '0;
    end else begin
      unique case (state)
        HUNT: begin
          if (match) begin
            realign        = 1'b1;
            match_cnt_next = 8'd1;
            state_next     = (LOCK_COUNT == 1) ? LOCKED : LOCKING;
          end
        end
        LOCKING: begin
          if (boundary) begin
            if (match) begin
              match_cnt_next = match_cnt + 8'd1;
              if (match_cnt_next == LOCK_TARGET) state_next = LOCKED;
            end else begin
              state_next     = HUNT;
              match_cnt_next = '0;
            end
          end
        end
        LOCKED: ;
        default: begin
          state_next     = HUNT;
          match_cnt_next = '0;
        end
      endcase
    end
  end

  // Training words at a boundary are idle fill; a capture error kills that cycle's word.
  always_comb begin
    emit = 1'b0;
    if (state == LOCKED && boundary && !match && !capture_err_i) emit = 1'b1;
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      sr           <= '0;
      phase        <= '0;
      match_cnt    <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      sr           <= {sr[27:0], data_i};
      phase        <= realign ? '0 : phase + 1'b1;
      match_cnt    <= match_cnt_next;
      word_valid_o <= emit;
      locked_o     <= (state_next == LOCKED);
      if (emit) word_o <= sr;
    end
  end

  sat_event_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_counter (
    .sysclk_i (sysclk_i),
    .rst_i    (rst_i),
    .inc      (capture_err_i),
    .clr      (err_clr_i),
    .count    (err_count_o)
  );

endmodule
